// File: rtl/sprite_mem_arbiter.sv
// Sprite RAM arbiter: renderer reads have priority over buffered SPI writes.
// Define SPRITE_ARB_STARVE_EN to compile in the write starvation guard.
module sprite_mem_arbiter #(
    parameter int WFIFO_DEPTH      = 4,
    parameter int STARVE_LIMIT     = 8,
    parameter int SPRITE_NUM       = 8,
    parameter int SPRITE_ADDR_SIZE = 7,
    localparam int SW = $clog2(SPRITE_NUM),
    localparam int AW = SPRITE_ADDR_SIZE + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          w_en,
    input  logic [SW-1:0] w_sel,
    input  logic [AW-1:0] w_addr,
    input  logic [7:0]    w_data,
    output logic          w_overflow,
    input  logic          r_req,
    input  logic [SW-1:0] r_sel,
    input  logic [AW-1:0] r_addr,
    output logic          r_ack,
    output logic          r_valid,
    output logic [7:0]    r_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [SW-1:0] mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy
);
    localparam int PW = $clog2(WFIFO_DEPTH);

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_ent_t;

    wr_ent_t       fifo_q [WFIFO_DEPTH];
    wr_ent_t       head;
    logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          fifo_empty, fifo_full, push, pop;
    logic          rd_gnt, wr_gnt, forced;
    logic          w_overflow_q, w_overflow_d;
    logic          r_ack_q, r_ack_d, r_valid_q, r_valid_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [SW-1:0] mem_sel_q, mem_sel_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;

    // Extra MSB on the pointers separates full from empty.
    assign fifo_empty = wr_ptr_q == rd_ptr_q;
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head       = fifo_q[rd_ptr_q[PW-1:0]];

`ifdef SPRITE_ARB_STARVE_EN
    logic [7:0] starve_cnt_q, starve_cnt_d;

    assign forced = starve_cnt_q >= 8'(STARVE_LIMIT);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || wr_gnt)
            starve_cnt_d = '0;
        else if (starve_cnt_q != 8'hFF)
            starve_cnt_d = starve_cnt_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) starve_cnt_q <= '0;
        else       starve_cnt_q <= starve_cnt_d;
    end
`else
    assign forced = 1'b0;
`endif

    always_comb begin
        rd_gnt       = r_req && !r_ack_q && !forced;
        wr_gnt       = !fifo_empty && !rd_gnt;
        pop          = wr_gnt;
        push         = w_en && (!fifo_full || pop);
        wr_ptr_d     = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d     = rd_ptr_q + {{PW{1'b0}}, pop};
        busy_d       = wr_ptr_d != rd_ptr_d;
        w_overflow_d = w_overflow_q || (w_en && !push);
        r_ack_d      = rd_gnt;
        r_valid_d    = r_ack_q;
        mem_en_d     = rd_gnt || wr_gnt;
        mem_we_d     = wr_gnt;
        mem_sel_d    = mem_sel_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if (rd_gnt) begin
            mem_sel_d  = r_sel;
            mem_addr_d = r_addr;
        end else if (wr_gnt) begin
            mem_sel_d   = head.sel;
            mem_addr_d  = head.addr;
            mem_wdata_d = head.data;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo_q[wr_ptr_q[PW-1:0]] <= '{sel: w_sel, addr: w_addr, data: w_data};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            busy_q       <= 1'b0;
            w_overflow_q <= 1'b0;
            r_ack_q      <= 1'b0;
            r_valid_q    <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_sel_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            busy_q       <= busy_d;
            w_overflow_q <= w_overflow_d;
            r_ack_q      <= r_ack_d;
            r_valid_q    <= r_valid_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_sel_q    <= mem_sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign w_overflow = w_overflow_q;
    assign r_ack      = r_ack_q;
    assign r_valid    = r_valid_q;
    assign r_data     = mem_rdata;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_sel    = mem_sel_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Scoreboard bench for sprite_mem_arbiter: directed scenarios then random traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_sprite_mem_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int SW    = 3;
    localparam int AW    = 8;
`ifdef SPRITE_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          w_en = 1'b0;
    logic [SW-1:0] w_sel = '0;
    logic [AW-1:0] w_addr = '0;
    logic [7:0]    w_data = '0;
    logic          w_overflow;
    logic          r_req = 1'b0;
    logic [SW-1:0] r_sel = '0;
    logic [AW-1:0] r_addr = '0;
    logic          r_ack, r_valid;
    logic [7:0]    r_data;
    logic          mem_en, mem_we;
    logic [SW-1:0] mem_sel;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sprite_mem_arbiter #(.WFIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .w_en(w_en), .w_sel(w_sel), .w_addr(w_addr), .w_data(w_data),
        .w_overflow(w_overflow),
        .r_req(r_req), .r_sel(r_sel), .r_addr(r_addr),
        .r_ack(r_ack), .r_valid(r_valid), .r_data(r_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // RAM attached to the DUT
    logic [7:0] ram [8][256];
    always @(posedge clock) begin
        if (mem_en === 1'b1) begin
            if (mem_we) ram[mem_sel][mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_sel][mem_addr];
        end
    end

    typedef struct {bit [SW-1:0] sel; bit [AW-1:0] addr; bit [7:0] data;} wr_t;
    typedef struct {bit we; bit [SW-1:0] sel; bit [AW-1:0] addr; bit [7:0] data;} op_t;
    typedef struct {bit rst; bit en; bit ack; bit valid; bit busy; bit ovf;} st_t;

    wr_t       m_fifo[$];
    op_t       op_q[$];
    st_t       st_q[$];
    bit [7:0]  rd_q[$];
    bit [7:0]  m_ram [8][256];
    bit        m_ack, m_ovf, m_rv_pend;
    bit [7:0]  m_rv_data;
    int        m_cnt;

    initial begin
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 256; j++) begin
                ram[i][j]   = 8'(i * 37 + j * 5);
                m_ram[i][j] = 8'(i * 37 + j * 5);
            end
        ram[1][8'h20]   = 8'h3C;
        m_ram[1][8'h20] = 8'h3C;
    end

    // Reference model: what the DUT must show during the next cycle
    always @(posedge clock) begin : model
        st_t s;
        op_t o;
        wr_t e;
        bit  rg, wg;
        s = '{default: 0};
        if (reset) begin
            m_fifo.delete();
            m_ack = 0; m_ovf = 0; m_cnt = 0; m_rv_pend = 0;
            s.rst = 1;
        end else begin
            rg = r_req && !m_ack && !(STARVE && m_cnt >= LIMIT);
            wg = !rg && m_fifo.size() > 0;
            if (m_fifo.size() == 0 || wg) m_cnt = 0;
            else if (m_cnt < 255) m_cnt++;
            s.valid = m_rv_pend;
            if (m_rv_pend) rd_q.push_back(m_rv_data);
            m_rv_pend = rg;
            if (rg) begin
                m_rv_data = m_ram[r_sel][r_addr];
                o = '{we: 0, sel: r_sel, addr: r_addr, data: 0};
                op_q.push_back(o);
            end
            if (wg) begin
                e = m_fifo.pop_front();
                m_ram[e.sel][e.addr] = e.data;
                o = '{we: 1, sel: e.sel, addr: e.addr, data: e.data};
                op_q.push_back(o);
            end
            if (w_en) begin
                if (m_fifo.size() < DEPTH)
                    m_fifo.push_back('{sel: w_sel, addr: w_addr, data: w_data});
                else
                    m_ovf = 1;
            end
            m_ack  = rg;
            s.en   = rg || wg;
            s.ack  = rg;
            s.busy = m_fifo.size() > 0;
            s.ovf  = m_ovf;
        end
        st_q.push_back(s);
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents outputs
    always @(negedge clock) begin : monitor
        st_t s;
        op_t o;
        bit [7:0] d;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("mem_en", 32'(mem_en), 32'(s.en));
            chk("r_ack", 32'(r_ack), 32'(s.ack));
            chk("r_valid", 32'(r_valid), 32'(s.valid));
            chk("busy", 32'(busy), 32'(s.busy));
            chk("w_overflow", 32'(w_overflow), 32'(s.ovf));
            if (s.rst) begin
                chk("rst_mem_we", 32'(mem_we), 0);
                chk("rst_mem_sel", 32'(mem_sel), 0);
                chk("rst_mem_addr", 32'(mem_addr), 0);
                chk("rst_mem_wdata", 32'(mem_wdata), 0);
            end
        end
        if (mem_en === 1'b1) begin
            if (op_q.size() == 0) begin
                chk("mem_op_unexpected", 1, 0);
            end else begin
                o = op_q.pop_front();
                chk("mem_we", 32'(mem_we), 32'(o.we));
                chk("mem_sel", 32'(mem_sel), 32'(o.sel));
                chk("mem_addr", 32'(mem_addr), 32'(o.addr));
                if (o.we) chk("mem_wdata", 32'(mem_wdata), 32'(o.data));
            end
        end
        if (r_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("r_valid_unexpected", 1, 0);
            end else begin
                d = rd_q.pop_front();
                chk("r_data", 32'(r_data), 32'(d));
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(int s, int a, int d);
        w_en = 1; w_sel = SW'(s); w_addr = AW'(a); w_data = 8'(d);
        @(negedge clock);
        w_en = 0;
    endtask

    task automatic wait_ack();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (r_ack) seen = 1;
        end
        if (!seen) chk("r_ack_timeout", 0, 1);
        r_req = 0;
    endtask

    initial begin
        cyc(3);
        reset = 0;
        // single write
        wr(2, 8'h10, 8'hA5);
        cyc(4);
        // single read
        r_req = 1; r_sel = 1; r_addr = 8'h20;
        wait_ack();
        cyc(4);
        // back-to-back writes under continuous reads
        r_req = 1; r_sel = 3; r_addr = 8'h05;
        for (int i = 0; i < 5; i++) wr(i, 8'h40 + i, 8'h11 * (i + 1));
        cyc(20);
        r_req = 0;
        cyc(6);
        // one queued write with reads held
        r_req = 1;
        wr(5, 8'h77, 8'h5A);
        cyc(15);
        r_req = 0;
        cyc(4);
        // same-cycle write and read on an empty FIFO
        r_req = 1; r_sel = 6; r_addr = 8'h33;
        wr(6, 8'h34, 8'hC3);
        wait_ack();
        cyc(5);
        // reset right after a read grant with writes queued
        r_req = 1; r_sel = 2; r_addr = 8'h10;
        w_en = 1; w_sel = 1; w_addr = 8'h01; w_data = 8'h99;
        @(negedge clock);
        w_sel = 1; w_addr = 8'h02; w_data = 8'h98;
        reset = 1;
        @(negedge clock);
        w_en = 0; r_req = 0;
        @(negedge clock);
        reset = 0;
        cyc(4);
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            w_en   = ($urandom_range(0, 9) < 4);
            w_sel  = SW'($urandom_range(0, 3));
            w_addr = AW'($urandom_range(0, 15));
            w_data = 8'($urandom);
            if (r_req && r_ack) begin
                if ($urandom_range(0, 1) == 1) begin
                    r_sel  = SW'($urandom_range(0, 3));
                    r_addr = AW'($urandom_range(0, 15));
                end else begin
                    r_req = 0;
                end
            end else if (!r_req && $urandom_range(0, 2) == 0) begin
                r_req  = 1;
                r_sel  = SW'($urandom_range(0, 3));
                r_addr = AW'($urandom_range(0, 15));
            end
            if (c == 1500) begin
                reset = 1; w_en = 0; r_req = 0;
                @(negedge clock);
                reset = 0;
            end
            @(negedge clock);
        end
        w_en = 0;
        r_req = 0;
        for (int i = 0; i < 50 && (op_q.size() + rd_q.size()) > 0; i++)
            @(negedge clock);
        cyc(2);
        chk("drain_ops", 32'(op_q.size()), 0);
        chk("drain_reads", 32'(rd_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
